// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request check for the load/store unit.
// Imported by lsu_align and lsu_mem_ctrl.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    ERR      = 2'd3
  } state_t;

  // Illegal funct3, misalignment or an address beyond the memory.
  function automatic logic req_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off,
    input logic       oor
  );
    logic ill;
    logic mis;
    if (we)
      ill = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else
      ill = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
              f3 == F3_BU || f3 == F3_HU);
    mis = (f3[1:0] == 2'b01 && off[0]) ||
          (f3[1:0] == 2'b10 && off != 2'b00);
    return ill | mis | oor;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extends load data and merges sub-word store data.
// Ports: word/off/funct3/wdata in; ld (extended load), st (merged word) out.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] ld,
  output logic [31:0] st
);

  logic [31:0] sh;

  assign sh = word >> {off, 3'b000};

  always_comb begin
    ld = sh;
    unique case (1'b1)
      funct3 == F3_B:  ld = {{24{sh[7]}}, sh[7:0]};
      funct3 == F3_BU: ld = {24'h0, sh[7:0]};
      funct3 == F3_H:  ld = {{16{sh[15]}}, sh[15:0]};
      funct3 == F3_HU: ld = {16'h0, sh[15:0]};
      default:         ld = sh;
    endcase
  end

  always_comb begin
    st = word;
    if (funct3[1:0] == 2'b00)
      st[{off, 3'b000} +: 8] = wdata[7:0];
    else if (funct3[1:0] == 2'b01)
      st[{off[1], 4'b0000} +: 16] = wdata;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word memory without byte enables.
// Ports: req_* handshake in, resp_* pulse out, mem_* word-memory port.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [31:0]  req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [M-1:0] mem_adrs_r,
  output logic [M-1:0] mem_adrs_w,
  output logic [N-1:0] mem_data_w,
  output logic         mem_WE,
  input  logic [N-1:0] mem_data_r
);

  state_t       state;
  state_t       nstate;
  logic         op_we;
  logic [2:0]   op_f3;
  logic [1:0]   op_off;
  logic [M-1:0] op_wadr;
  logic [N-1:0] op_wdata;
  logic [N-1:0] merge;
  logic [N-1:0] ld_data;
  logic [N-1:0] st_data;
  logic         accept;
  logic         bad;
  logic         sw_op;

  assign accept = (state == IDLE) && req_valid;
  assign bad    = req_bad(req_we, req_funct3, req_addr[1:0],
                          |req_addr[31:M+2]);
  assign sw_op  = op_we && (op_f3 == F3_W);

  assign mem_adrs_r = op_wadr;
  assign mem_adrs_w = op_wadr;

  lsu_align u_align (
    .word   (mem_data_r),
    .off    (op_off),
    .funct3 (op_f3),
    .wdata  (op_wdata[15:0]),
    .ld     (ld_data),
    .st     (st_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate     = state;
    req_ready  = 1'b0;
    mem_WE     = 1'b0;
    mem_data_w = op_wdata;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nstate = bad ? ERR : ACCESS;
      end
      ACCESS: begin
        mem_WE = sw_op;
        nstate = (op_we && !sw_op) ? MERGE_WR : IDLE;
      end
      MERGE_WR: begin
        mem_WE     = 1'b1;
        mem_data_w = merge;
        nstate     = IDLE;
      end
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_we      <= 1'b0;
      op_f3      <= 3'b000;
      op_off     <= 2'b00;
      op_wadr    <= '0;
      op_wdata   <= '0;
      merge      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (accept) begin
        op_we    <= req_we;
        op_f3    <= req_funct3;
        op_off   <= req_addr[1:0];
        op_wadr  <= req_addr[M+1:2];
        op_wdata <= req_wdata;
      end
      unique case (state)
        ACCESS: begin
          if (!op_we) begin
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
          end else if (sw_op) begin
            resp_valid <= 1'b1;
          end else begin
            merge <= st_data;
          end
        end
        MERGE_WR: resp_valid <= 1'b1;
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory.
// Table of single requests plus reset-abort and back-to-back sequences.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_adrs_r;
  logic [9:0]  mem_adrs_w;
  logic [31:0] mem_data_w;
  logic        mem_WE;
  logic [31:0] mem_data_r;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data_r = mem[mem_adrs_r];

  always @(posedge clk)
    if (mem_WE) mem[mem_adrs_w] <= mem_data_w;

  lsu_mem_ctrl #(.N(32), .M(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_adrs_r (mem_adrs_r),
    .mem_adrs_w (mem_adrs_w),
    .mem_data_w (mem_data_w),
    .mem_WE     (mem_WE),
    .mem_data_r (mem_data_r)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request and follow it to its response.
  task automatic do_req(input vec_t v, input string nm);
    int lat;
    bit done;
    bit we_seen;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    req_we     = 1'($urandom);
    lat = 1;
    done = 0;
    we_seen = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (mem_WE) we_seen = 1;
      if (resp_valid) done = 1;
      else lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no response expected one", nm);
    end else begin
      chk({nm, "_rdata"}, resp_rdata, v.rdata);
      chk({nm, "_err"}, 32'(resp_err), 32'(v.err));
      chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
      chk({nm, "_we"}, 32'(we_seen), 32'(v.we && !v.err));
      @(negedge clk);
      chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    bit bad_resp;
    int k;
    int nresp;
    int last_acc;
    bit prev_v;
    logic [31:0] b2b_addr [3];
    logic [2:0]  b2b_f3 [3];
    logic [31:0] b2b_exp [3];

    vt.push_back(vec_t'{1'b1, F3_W,  32'h10, 32'hA1B2C3D4, 32'h0, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0, 32'hA1B2C3D4, 1'b0, 2});
    vt.push_back(vec_t'{1'b1, F3_B,  32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 3});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0, 32'hA1B255D4, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFA1, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_BU, 32'h13, 32'h0, 32'h000000A1, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFA1B2, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_HU, 32'h12, 32'h0, 32'h0000A1B2, 1'b0, 2});
    vt.push_back(vec_t'{1'b1, F3_H,  32'h12, 32'hABCD1234, 32'h0, 1'b0, 3});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0, 32'h123455D4, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFD4, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_B,  32'h11, 32'h0, 32'h00000055, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_H,  32'h10, 32'h0, 32'h000055D4, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h11, 32'h0, 32'h0, 1'b1, 2});
    vt.push_back(vec_t'{1'b1, F3_H,  32'h03, 32'h9999, 32'h0, 1'b1, 2});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h1000, 32'h0, 32'h0, 1'b1, 2});
    vt.push_back(vec_t'{1'b1, F3_BU, 32'h10, 32'h77, 32'h0, 1'b1, 2});
    vt.push_back(vec_t'{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h10, 32'h0, 32'h123455D4, 1'b0, 2});
    vt.push_back(vec_t'{1'b1, F3_W,  32'hFFC, 32'hDEADBEEF, 32'h0, 1'b0, 2});
    vt.push_back(vec_t'{1'b0, F3_W,  32'hFFC, 32'h0, 32'hDEADBEEF, 1'b0, 2});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h20, 32'h11223344, 32'h0, 1'b0, 2});

    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_we", 32'(mem_WE), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) do_req(vt[i], $sformatf("vec%0d", i));

    // Reset while the merged word is being written.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h20;
    req_wdata  = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midsb_we_on", 32'(mem_WE), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("midsb_we_off", 32'(mem_WE), 32'd0);
    chk("midsb_valid", 32'(resp_valid), 32'd0);
    chk("midsb_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) bad_resp = 1;
    end
    chk("midsb_noresp", 32'(bad_resp), 32'd0);
    do_req(vec_t'{1'b0, F3_W, 32'h20, 32'h0, 32'h11223344, 1'b0, 2},
           "midsb_word");

    // Back-to-back loads with req_valid held high.
    b2b_addr[0] = 32'h10;  b2b_f3[0] = F3_W;  b2b_exp[0] = 32'h123455D4;
    b2b_addr[1] = 32'hFFC; b2b_f3[1] = F3_W;  b2b_exp[1] = 32'hDEADBEEF;
    b2b_addr[2] = 32'h12;  b2b_f3[2] = F3_HU; b2b_exp[2] = 32'h00001234;
    k = 0;
    nresp = 0;
    last_acc = 0;
    prev_v = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        chk("b2b_pulse", 32'(prev_v), 32'd0);
        if (nresp < 3) chk($sformatf("b2b_rdata%0d", nresp),
                           resp_rdata, b2b_exp[nresp]);
        nresp++;
      end
      prev_v = resp_valid;
      if (req_ready) begin
        if (k < 3) begin
          if (k > 0) chk("b2b_interval", 32'(c - last_acc), 32'd2);
          last_acc   = c;
          req_valid  = 1'b1;
          req_we     = 1'b0;
          req_funct3 = b2b_f3[k];
          req_addr   = b2b_addr[k];
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (k == 3 && nresp == 3) break;
    end
    req_valid = 1'b0;
    chk("b2b_count", 32'(nresp), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller sitting directly upstream of the word-wide data memory, between the execute stage and the memory.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the memory's single-write-enable port.
- Sub-word stores use a read-modify-write sequence, because the memory has no byte enables.
- Performs alignment, sign/zero extension and range checks, and returns one response per accepted request.

Parameters:
- N, 32, data width in bits (fixed at 32 for byte-lane logic).
- M, 10, memory word-address width; the memory holds 2**M words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 size/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  N  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  N  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal funct3.
- mem_adrs_r  output  M  memory read word address.
- mem_adrs_w  output  M  memory write word address.
- mem_data_w  output  N  memory write data.
- mem_WE  output  1  memory write enable.
- mem_data_r  input  N  memory read data (combinational read).

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE.
  - req_ready=1 once in IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_WE=0.
  - All internal request registers are cleared.
  - A reset mid-sequence aborts it: no write is issued and no response is produced.
- Handshake:
  - A request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE.
  - Request fields are latched on acceptance; inputs are don't-care afterwards.
  - There is no response backpressure.
- States: IDLE, ACCESS, MERGE_WR, ERR.
- IDLE, on accept:
  - Go to ERR if any of these hold: funct3 illegal (loads: only 000, 001, 010, 100, 101; stores: only 000, 001, 010); halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:M+2]!=0.
  - Otherwise go to ACCESS.
- ERR: lasts one cycle, performs no memory access, then returns to IDLE with resp_valid=1, resp_err=1, resp_rdata=0.
- ACCESS:
  - mem_adrs_r = mem_adrs_w = latched addr[M+1:2].
  - Load: lane is selected by addr[1:0], little-endian. LB/LH sign-extend; LBU/LHU zero-extend. The extended data is registered into resp_rdata. Return to IDLE with resp_valid=1.
  - SW: mem_WE=1 and mem_data_w=wdata this cycle. Return to IDLE with resp_valid=1 and resp_rdata=0.
  - SB/SH: mem_data_r is merged with wdata[7:0] or wdata[15:0] at the selected lane into a merge register. Go to MERGE_WR.
- MERGE_WR: mem_WE=1 and mem_data_w=merge register. Return to IDLE with resp_valid=1.
- mem_WE is decoded from state and latched op only, never directly from inputs, so it is never asserted in IDLE or ERR.
- Latency from accept edge to resp_valid edge:
  - loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - errors: 2 cycles.
- Back-to-back: the response cycle is an IDLE cycle, so a new request may be accepted in the same cycle that resp_valid is high.
- Outputs resp_valid and resp_err are registered. Both are high for exactly one cycle per accepted request.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state encoding: IDLE, ACCESS, MERGE_WR, ERR.
  - the error-check function.
- One combinational sub-module, lsu_align, is natural. Inputs are word, offset, funct3 and wdata. Outputs are the extended load value and the merged store word. It is reused for both load and store paths.

Test Plan:
- Reset mid-SB (rst low during MERGE_WR) -> mem_WE drops immediately; no resp_valid; the memory word is unchanged after release.
- SW addr=0x10, data=0xA1B2C3D4, then LW addr=0x10 -> mem_WE pulse at word 4; load resp 2 cycles after accept with rdata=0xA1B2C3D4, err=0.
- Word 4 = 0xA1B2C3D4; SB addr=0x11, data=0x55 -> 3-cycle latency; word 4 becomes 0xA1B255D4. LB addr=0x13 -> 0xFFFFFFA1. LBU addr=0x13 -> 0x000000A1.
- LH addr=0x12 on 0xA1B255D4 -> 0xFFFFA1B2. LHU -> 0x0000A1B2. SH addr=0x12, data=0x1234 -> word becomes 0x123455D4.
- Errors: LW addr=0x11, SH addr=0x03, LW addr=0x00001000 (M=10), and store with funct3=100 -> each gives resp_err=1, rdata=0, no mem_WE, latency 2 cycles.
- Back-to-back loads with req_valid held high -> accepts occur every 2 cycles, each resp_valid is a single-cycle pulse, and responses arrive in request order.
